memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Sequential arbiter that shares the single-ported unified RAM between the instruction fetch port (iREN) and the data port (dREN/dWEN) produced by the control unit and datapath. It grants one port at a time and latches that port's request for the whole RAM transaction. It gives the data port priority, with a bounded starvation guard for instruction fetch. It sits between the datapath request unit and the RAM model.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while iREN is pending before instruction fetch is forced (range 1-15)
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iwait  out  1  0 only in the cycle the instruction read completes
- iload  out  32  instruction word, valid when iwait=0
- dREN  in  1  data read request
- dWEN  in  1  data write request; wins over dREN if both are set
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  0 only in the cycle the data access completes
- dload  out  32  data read value, valid when dwait=0 on a read
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- mem_err  out  1  sticky error flag, cleared only by nRST

## Operation
- States: IDLE, IGRANT, DGRANT.
- IDLE:
  - If dREN or dWEN is set and starve_cnt < STARVE_LIMIT: go to DGRANT.
  - Else if iREN is set: go to IGRANT.
  - Else if dREN or dWEN is set: go to DGRANT. This covers the case where the limit is reached but iREN has since dropped.
  - On any transition, latch the chosen port's address, store data and write flag into req_* registers.
- In IGRANT or DGRANT:
  - ramREN = !req_wr and ramWEN = req_wr, both driven from the latched copies.
  - ramaddr = req_addr and ramstore = req_store.
  - Input changes are ignored until completion.
- Completion: a cycle in a grant state where ramstate=ACCESS.
  - The granted port's wait output goes 0 and its load output equals ramload, both combinationally in that cycle.
  - Next state is IDLE.
- starve_cnt (4 bits):
  - +1, saturating, on each DGRANT completion where iREN=1 in that cycle.
  - Cleared on IGRANT completion.
  - Cleared on any cycle in IDLE with iREN=0.
- ramstate=ERROR in a grant state: set mem_err and stay in the grant state (retry). Wait stays 1.
- Requester drops its request mid-grant: the transaction still completes, because writes must not be torn. The wait pulse is still produced and the requester ignores it.
- Outside completion cycles: iwait=1, dwait=1, iload=0, dload=0.
- In IDLE: ramREN=0, ramWEN=0, ramaddr and ramstore hold their last value.

## Timing
- Reset (nRST=0, asynchronous): state=IDLE, starve_cnt=0, req_*=0, mem_err=0, iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N drives the RAM from edge N onward.
- Minimum access (ramstate=ACCESS in the first grant cycle): wait=0 one cycle after the request is raised. This gives at most one completion per 2 cycles.
- Back-to-back requests: IDLE is visited for exactly 1 cycle between grants.
- Simultaneous iREN and dREN in IDLE: data wins unless starve_cnt >= STARVE_LIMIT.
- nRST asserted mid-grant: the transaction is abandoned and the RAM enables drop immediately.
- Wait and load outputs are combinational from ramstate and ramload. No other path from ramload is registered.

## Test plan
- Reset: hold nRST=0 with requests asserted -> iwait=dwait=1, ramREN=ramWEN=0, mem_err=0. Release nRST -> first grant next cycle.
- Single instruction fetch:
  - iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C220004.
  - Required: ramREN=1, ramaddr=0x40 for 3 cycles, then iwait=0 and iload=0x8C220004 for exactly 1 cycle.
- Data write priority:
  - iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) in the same cycle.
  - Required: DGRANT first with ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF, and dwait=0 on ACCESS. IGRANT follows after 1 IDLE cycle.
- Starvation guard:
  - STARVE_LIMIT=4, iREN and dREN held continuously, RAM always ACCESS.
  - Required: 4 data completions, then 1 instruction completion, repeating.
- Mid-transaction change and error:
  - During DGRANT, change daddr to 0x200 and drop dWEN -> ramaddr stays 0x100 until completion.
  - Inject ramstate=ERROR for 1 cycle -> mem_err=1 sticky, the access retries, and completes on the later ACCESS.
- Async reset mid-grant:
  - Pulse nRST low between clock edges during IGRANT.
  - Required: ramREN=0 immediately, state=IDLE, mem_err=0, and the next request is granted normally.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Request/RAM bundle around the unified-memory arbiter.
// slave is the arbiter's view, master is the requester/RAM environment view.
interface memory_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        mem_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore, mem_err
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares the single-ported RAM between instruction fetch and data port.
// Data has priority; a starvation counter forces a fetch after STARVE_LIMIT.
module memory_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic             CLK,
    input logic             nRST,
    memory_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    state_t      state, state_n;
    logic [3:0]  starve_cnt, starve_n;
    logic [31:0] req_addr, req_addr_n;
    logic [31:0] req_store, req_store_n;
    logic        req_wr, req_wr_n;
    logic        mem_err, mem_err_n;

    logic d_req, sel_d, sel_i;
    logic grant, i_done, d_done, ram_err;

    assign d_req   = bus.dREN | bus.dWEN;
    // data wins unless starved, but only while a fetch is actually waiting
    assign sel_d   = d_req & ((starve_cnt < LIMIT) | ~bus.iREN);
    assign sel_i   = bus.iREN & ~sel_d;
    assign grant   = (state != IDLE);
    assign i_done  = (state == IGRANT) & (bus.ramstate == RAM_ACCESS);
    assign d_done  = (state == DGRANT) & (bus.ramstate == RAM_ACCESS);
    assign ram_err = grant & (bus.ramstate == RAM_ERROR);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            req_addr   <= '0;
            req_store  <= '0;
            req_wr     <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            req_addr   <= req_addr_n;
            req_store  <= req_store_n;
            req_wr     <= req_wr_n;
            mem_err    <= mem_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        starve_n    = starve_cnt;
        req_addr_n  = req_addr;
        req_store_n = req_store;
        req_wr_n    = req_wr;
        mem_err_n   = mem_err | ram_err;
        case (state)
            IDLE: begin
                if (!bus.iREN)
                    starve_n = '0;
                if (sel_d) begin
                    state_n     = DGRANT;
                    req_addr_n  = bus.daddr;
                    req_store_n = bus.dstore;
                    req_wr_n    = bus.dWEN;
                end else if (sel_i) begin
                    state_n     = IGRANT;
                    req_addr_n  = bus.iaddr;
                    req_store_n = '0;
                    req_wr_n    = 1'b0;
                end
            end
            IGRANT: begin
                if (i_done) begin
                    state_n  = IDLE;
                    starve_n = '0;
                end
            end
            DGRANT: begin
                if (d_done) begin
                    state_n = IDLE;
                    if (bus.iREN && starve_cnt != 4'hF)
                        starve_n = starve_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ramREN   = grant & ~req_wr;
    assign bus.ramWEN   = grant & req_wr;
    assign bus.ramaddr  = req_addr;
    assign bus.ramstore = req_store;
    assign bus.iwait    = ~i_done;
    assign bus.dwait    = ~d_done;
    assign bus.iload    = i_done ? bus.ramload : '0;
    assign bus.dload    = d_done ? bus.ramload : '0;
    assign bus.mem_err  = mem_err;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, fetch, priority,
// starvation guard, mid-grant change, RAM error and async reset.
module tb_memory_arbiter;

    logic CLK = 1'b0;
    logic nRST;
    int   n_err = 0;
    int   n_checks = 0;

    memory_arbiter_if bus ();

    memory_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        nRST         = 1'b0;
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h40;
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'h0;
        bus.dstore   = 32'h0;
        bus.ramload  = 32'h0;
        bus.ramstate = 2'd0;

        // reset held with requests pending
        tick();
        chk("rst_iwait", 32'(bus.iwait), 32'd1);
        chk("rst_dwait", 32'(bus.dwait), 32'd1);
        chk("rst_ren", 32'(bus.ramREN), 32'd0);
        chk("rst_wen", 32'(bus.ramWEN), 32'd0);
        chk("rst_err", 32'(bus.mem_err), 32'd0);
        chk("rst_addr", bus.ramaddr, 32'h0);
        chk("rst_iload", bus.iload, 32'h0);

        // single fetch, two BUSY cycles then ACCESS
        bus.dREN     = 1'b0;
        bus.ramstate = 2'd1;
        nRST         = 1'b1;
        tick();
        chk("if_ren0", 32'(bus.ramREN), 32'd1);
        chk("if_addr0", bus.ramaddr, 32'h40);
        chk("if_wait0", 32'(bus.iwait), 32'd1);
        tick();
        chk("if_ren1", 32'(bus.ramREN), 32'd1);
        chk("if_addr1", bus.ramaddr, 32'h40);
        chk("if_wait1", 32'(bus.iwait), 32'd1);
        tick();
        bus.ramstate = 2'd2;
        bus.ramload  = 32'h8C22_0004;
        #1;
        chk("if_ren2", 32'(bus.ramREN), 32'd1);
        chk("if_wait2", 32'(bus.iwait), 32'd0);
        chk("if_load", bus.iload, 32'h8C22_0004);
        chk("if_dwait", 32'(bus.dwait), 32'd1);
        bus.iREN = 1'b0;
        tick();
        bus.ramstate = 2'd0;
        #1;
        chk("if_idle_wait", 32'(bus.iwait), 32'd1);
        chk("if_idle_load", bus.iload, 32'h0);
        chk("if_idle_ren", 32'(bus.ramREN), 32'd0);
        chk("if_idle_addr", bus.ramaddr, 32'h40);

        // simultaneous fetch and write: data first
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h44;
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h100;
        bus.dstore   = 32'hDEAD_BEEF;
        bus.ramstate = 2'd2;
        tick();
        chk("pr_wen", 32'(bus.ramWEN), 32'd1);
        chk("pr_ren", 32'(bus.ramREN), 32'd0);
        chk("pr_addr", bus.ramaddr, 32'h100);
        chk("pr_store", bus.ramstore, 32'hDEAD_BEEF);
        chk("pr_dwait", 32'(bus.dwait), 32'd0);
        chk("pr_iwait", 32'(bus.iwait), 32'd1);
        bus.dWEN = 1'b0;
        tick();
        chk("pr_idle_wen", 32'(bus.ramWEN), 32'd0);
        chk("pr_idle_dwait", 32'(bus.dwait), 32'd1);
        chk("pr_idle_iwait", 32'(bus.iwait), 32'd1);
        tick();
        chk("pr_i_ren", 32'(bus.ramREN), 32'd1);
        chk("pr_i_addr", bus.ramaddr, 32'h44);
        chk("pr_i_wait", 32'(bus.iwait), 32'd0);
        chk("pr_i_load", bus.iload, 32'h8C22_0004);
        bus.iREN = 1'b0;
        tick();

        // starvation guard: D D D D I, repeating
        bus.iREN    = 1'b1;
        bus.iaddr   = 32'h48;
        bus.dREN    = 1'b1;
        bus.daddr   = 32'h300;
        bus.ramload = 32'h1111_2222;
        for (int k = 0; k < 20; k++) begin
            logic exp_d, exp_i;
            tick();
            exp_d = (k % 2 == 0) && ((k / 2) % 5 != 4);
            exp_i = (k % 2 == 0) && ((k / 2) % 5 == 4);
            chk($sformatf("sv_dwait%0d", k), 32'(bus.dwait), 32'(!exp_d));
            chk($sformatf("sv_iwait%0d", k), 32'(bus.iwait), 32'(!exp_i));
        end
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        tick();

        // mid-grant input change and RAM error retry
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h100;
        bus.dstore   = 32'h1234_5678;
        bus.ramstate = 2'd1;
        tick();
        chk("mc_addr0", bus.ramaddr, 32'h100);
        chk("mc_wen0", 32'(bus.ramWEN), 32'd1);
        chk("mc_store0", bus.ramstore, 32'h1234_5678);
        bus.daddr    = 32'h200;
        bus.dWEN     = 1'b0;
        bus.ramstate = 2'd3;
        #1;
        chk("mc_addr1", bus.ramaddr, 32'h100);
        chk("mc_wen1", 32'(bus.ramWEN), 32'd1);
        chk("mc_err_wait", 32'(bus.dwait), 32'd1);
        chk("mc_err0", 32'(bus.mem_err), 32'd0);
        tick();
        bus.ramstate = 2'd1;
        #1;
        chk("mc_err1", 32'(bus.mem_err), 32'd1);
        chk("mc_addr2", bus.ramaddr, 32'h100);
        chk("mc_retry_wen", 32'(bus.ramWEN), 32'd1);
        chk("mc_busy_wait", 32'(bus.dwait), 32'd1);
        tick();
        bus.ramstate = 2'd2;
        #1;
        chk("mc_done_wait", 32'(bus.dwait), 32'd0);
        chk("mc_done_addr", bus.ramaddr, 32'h100);
        tick();
        bus.ramstate = 2'd0;
        #1;
        chk("mc_idle_wen", 32'(bus.ramWEN), 32'd0);
        chk("mc_sticky", 32'(bus.mem_err), 32'd1);
        chk("mc_hold_addr", bus.ramaddr, 32'h100);

        // asynchronous reset during a fetch grant
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h80;
        bus.ramstate = 2'd1;
        tick();
        chk("ar_ren0", 32'(bus.ramREN), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("ar_ren1", 32'(bus.ramREN), 32'd0);
        chk("ar_err", 32'(bus.mem_err), 32'd0);
        chk("ar_iwait", 32'(bus.iwait), 32'd1);
        chk("ar_addr", bus.ramaddr, 32'h0);
        bus.iaddr = 32'h84;
        #1;
        nRST = 1'b1;
        tick();
        chk("ar_ren2", 32'(bus.ramREN), 32'd1);
        chk("ar_addr2", bus.ramaddr, 32'h84);
        bus.ramstate = 2'd2;
        bus.ramload  = 32'hCAFE_F00D;
        #1;
        chk("ar_iwait2", 32'(bus.iwait), 32'd0);
        chk("ar_iload", bus.iload, 32'hCAFE_F00D);
        bus.iREN = 1'b0;
        tick();

        // dWEN beats dREN, then a plain data read
        bus.dREN   = 1'b1;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h10;
        bus.dstore = 32'hA5A5_A5A5;
        tick();
        chk("rw_wen", 32'(bus.ramWEN), 32'd1);
        chk("rw_ren", 32'(bus.ramREN), 32'd0);
        chk("rw_dwait", 32'(bus.dwait), 32'd0);
        bus.dWEN = 1'b0;
        tick();
        chk("rw_idle_dwait", 32'(bus.dwait), 32'd1);
        tick();
        bus.ramload = 32'h0000_55AA;
        #1;
        chk("rd_ren", 32'(bus.ramREN), 32'd1);
        chk("rd_wen", 32'(bus.ramWEN), 32'd0);
        chk("rd_addr", bus.ramaddr, 32'h10);
        chk("rd_dwait", 32'(bus.dwait), 32'd0);
        chk("rd_dload", bus.dload, 32'h0000_55AA);
        bus.dREN = 1'b0;
        tick();
        chk("rd_idle_dload", bus.dload, 32'h0);
        chk("rd_idle_dwait", 32'(bus.dwait), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
